ft_recovery_ctrl: RTL and testbench
===================================

# ft_recovery_ctrl

Rollback engine for the fault-tolerant core. When a fault is flagged, it halts the core and reads the checkpoint back out of the checkpoint memory over its data-memory read port: registers x1..x31, then the PC. Each register is replayed into the core register file through a dedicated write port, and the PC is presented on a restore bus. It sits directly downstream of the checkpoint memory as the sole master of its req/gnt/rvalid interface.

## Interface
- BASE_ADDR, 32'h0, byte address of checkpoint word 0 (register x0 slot)
- PC_INDEX, 32, word index of the PC slot; register xN lives at word N
- clk_i  in  1  clock; everything rising-edge
- rst_ni  in  1  reset, asynchronous, active-low
- recover_i  in  1  fault detected; starts a rollback when sampled high in IDLE
- req_o  out  1  memory read request
- gnt_i  in  1  request accepted
- rvalid_i  in  1  read data valid
- addr_o  out  32  byte address, BASE_ADDR + (index << 2)
- rdata_i  in  32  read data
- err_i  in  1  read error, qualified by rvalid_i
- halt_o  out  1  stalls the core while a rollback runs
- rf_we_o  out  1  register-file write strobe
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- pc_valid_o  out  1  one-cycle pulse, pc_o valid
- pc_o  out  32  restored PC
- done_o  out  1  one-cycle pulse at end of rollback
- err_o  out  1  sticky abort flag

## Operation
- States: IDLE, REQ, WAIT, FIN.
- IDLE, recover_i=1:
  - index ← 1
  - err_o ← 0
  - → REQ
- REQ:
  - Drive req_o=1 and addr_o from index; hold both stable until gnt_i.
  - On gnt_i → WAIT.
- WAIT:
  - req_o=0. Wait any number of cycles for rvalid_i.
  - On rvalid_i with err_i=1: err_o ← 1, → FIN. Registers already written stay written; the PC is not restored.
  - On rvalid_i, index 1..31: register (rf_waddr_o ← index[4:0], rf_wdata_o ← rdata_i, rf_we_o ← 1 for the next cycle). Then index+1 → REQ, or PC_INDEX after 31.
  - On rvalid_i, index=PC_INDEX: pc_o ← rdata_i, → FIN.
- FIN:
  - done_o=1 for one cycle.
  - pc_valid_o=1 the same cycle, only if err_o=0.
  - → IDLE.
- x0 is never read or written. Exactly one request is outstanding at any time.
- halt_o = (state != IDLE), decoded from registered state.
- Ignored inputs:
  - recover_i outside IDLE
  - gnt_i outside REQ
  - rvalid_i outside WAIT
- Reset (asynchronous, any state):
  - state=IDLE, index=0
  - all outputs 0 (req_o, addr_o, halt_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_valid_o, pc_o, done_o, err_o)
  - A rollback cut off by reset is abandoned, not resumed.
- err_o holds until the next accepted recover_i or reset.
- addr_o arithmetic is 32-bit modulo; BASE_ADDR is not checked for alignment.

## Timing
- recover_i sampled at edge 0 → REQ in cycle 1; halt_o high from cycle 1.
- Against the checkpoint memory (gnt same cycle as req, rvalid one cycle later), each word takes 2 cycles:
  - REQ for x1 in cycle 1, WAIT in cycle 2.
  - rf_we_o for x1 in cycle 3, overlapping the REQ for x2.
- 32 words (x1..x31, then PC):
  - last rvalid in cycle 64
  - FIN in cycle 65: done_o and pc_valid_o high
  - IDLE in cycle 66, halt_o low
- Stalled gnt_i or rvalid_i stretches REQ or WAIT cycle for cycle; no timeout.
- rf_we_o is a single-cycle registered pulse per register, 31 pulses per clean rollback.

## Test plan
- Clean rollback: preload xN slot = 32'hA000_0000+N, PC slot = 32'h0000_0400; pulse recover_i.
  → 31 writes, x1..x31 in order, with matching data.
  → pc_o=32'h400 with pc_valid_o and done_o in cycle 65; halt_o high for cycles 1..65.
- Stalled slave: hold gnt_i low 3 cycles on x5, delay rvalid_i 2 cycles on x20.
  → req_o/addr_o stable while waiting (x5 addr_o = 32'h14); total duration 69 cycles; data unchanged.
- Error abort: assert err_i with the rvalid for x10.
  → rf writes x1..x9 only; done_o pulses; pc_valid_o stays 0; err_o=1 until the next recover_i clears it.
- Spurious inputs: recover_i re-pulsed mid-rollback, plus rvalid_i in IDLE.
  → no restart, no extra rf_we_o; 31 writes total.
- Reset mid-operation: drop rst_ni during the WAIT for x12.
  → all outputs 0 immediately; IDLE; a later recover_i restarts from x1.
- BASE_ADDR=32'h100 → first addr_o=32'h104, PC addr_o=32'h180.

Source files
------------

// File: rtl/ft_recovery_ctrl_if.sv
// Checkpoint-memory read port: single outstanding req/gnt/rvalid transaction.
// Signal suffixes are from the rollback controller's point of view.
interface ft_recovery_ctrl_if;
    logic        req_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic        err_i;
    logic [31:0] addr_o;
    logic [31:0] rdata_i;

    modport master (output req_o, addr_o, input gnt_i, rvalid_i, rdata_i, err_i);
    modport slave  (input req_o, addr_o, output gnt_i, rvalid_i, rdata_i, err_i);
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Rollback engine: halts the core, reads x1..x31 then the PC back from the
// checkpoint memory, replays registers into the RF and presents the PC.
module ft_recovery_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned PC_INDEX  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      recover_i,
    ft_recovery_ctrl_if.master        mem,
    output logic                      halt_o,
    output logic                      rf_we_o,
    output logic [4:0]                rf_waddr_o,
    output logic [31:0]               rf_wdata_o,
    output logic                      pc_valid_o,
    output logic [31:0]               pc_o,
    output logic                      done_o,
    output logic                      err_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_e;

    localparam logic [31:0] PC_IDX = 32'(PC_INDEX);

    state_e      state_q, state_d;
    logic [31:0] idx_q, idx_d;
    logic        rsp;
    logic        rsp_ok;
    logic        is_pc;

    assign rsp    = (state_q == WAIT) && mem.rvalid_i;
    assign rsp_ok = rsp && !mem.err_i;
    assign is_pc  = (idx_q == PC_IDX);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        halt_o     = (state_q != IDLE);
        mem.req_o  = 1'b0;
        mem.addr_o = '0;
        done_o     = 1'b0;
        pc_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (recover_i) begin
                    state_d = REQ;
                    idx_d   = 32'd1;
                end
            end
            REQ: begin
                // Address is held from idx_q, which only moves in WAIT.
                mem.req_o  = 1'b1;
                mem.addr_o = BASE_ADDR + (idx_q << 2);
                if (mem.gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem.rvalid_i) begin
                    if (mem.err_i || is_pc) begin
                        state_d = FIN;
                    end else begin
                        state_d = REQ;
                        idx_d   = (idx_q == 32'd31) ? PC_IDX : idx_q + 32'd1;
                    end
                end
            end
            FIN: begin
                done_o     = 1'b1;
                pc_valid_o = !err_o;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            pc_o       <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rf_we_o <= rsp_ok && !is_pc;
            if (rsp_ok && !is_pc) begin
                rf_waddr_o <= idx_q[4:0];
                rf_wdata_o <= mem.rdata_i;
            end
            if (rsp_ok && is_pc) pc_o <= mem.rdata_i;
            // Sticky until the next accepted rollback request.
            if (state_q == IDLE && recover_i) err_o <= 1'b0;
            else if (rsp && mem.err_i)        err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl with a behavioural checkpoint memory
// and queue-based scoreboards for RF writes and request addresses.
module tb_ft_recovery_ctrl;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic recover = 1'b0;
    logic recover_b = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    ft_recovery_ctrl_if bus ();
    ft_recovery_ctrl_if bus_b ();

    logic        halt, rf_we, pc_valid, done, err_o;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pc;
    logic        halt_b, rf_we_b, pc_valid_b, done_b, err_b;
    logic [4:0]  rf_waddr_b;
    logic [31:0] rf_wdata_b, pc_b;

    ft_recovery_ctrl #(.BASE_ADDR(32'h0), .PC_INDEX(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .recover_i(recover), .mem(bus),
        .halt_o(halt), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pc_valid_o(pc_valid), .pc_o(pc), .done_o(done), .err_o(err_o)
    );

    ft_recovery_ctrl #(.BASE_ADDR(32'h100), .PC_INDEX(32)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .recover_i(recover_b), .mem(bus_b),
        .halt_o(halt_b), .rf_we_o(rf_we_b), .rf_waddr_o(rf_waddr_b), .rf_wdata_o(rf_wdata_b),
        .pc_valid_o(pc_valid_b), .pc_o(pc_b), .done_o(done_b), .err_o(err_b)
    );

    // Checkpoint memory model for u_dut: per-word grant stall and rvalid latency.
    logic [31:0] mem [0:63];
    int          gnt_hold [0:63];
    int          rv_lat [0:63];
    logic [5:0]  err_idx = '0;
    logic        spur_rv = 1'b0;
    int          gwait;
    logic        pend;
    logic [5:0]  pidx;
    int          dcnt;
    logic [5:0]  cur_idx;

    assign cur_idx      = bus.addr_o[7:2];
    assign bus.gnt_i    = bus.req_o && (gwait >= gnt_hold[cur_idx]);
    assign bus.rvalid_i = (pend && dcnt == 0) || spur_rv;
    assign bus.rdata_i  = pend ? mem[pidx] : 32'hDEAD_BEEF;
    assign bus.err_i    = pend && (err_idx != 6'd0) && (pidx == err_idx);

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            gwait <= 0; pend <= 1'b0; pidx <= '0; dcnt <= 0;
        end else begin
            gwait <= (bus.req_o && !bus.gnt_i) ? gwait + 1 : 0;
            if (bus.req_o && bus.gnt_i) begin
                pend <= 1'b1; pidx <= cur_idx; dcnt <= rv_lat[cur_idx] - 1;
            end else if (pend) begin
                if (dcnt == 0) pend <= 1'b0;
                else           dcnt <= dcnt - 1;
            end
        end
    end

    // Zero-wait memory for u_dut_b; read data echoes the request address.
    logic        pend_b;
    logic [31:0] raddr_b;
    assign bus_b.gnt_i    = bus_b.req_o;
    assign bus_b.rvalid_i = pend_b;
    assign bus_b.rdata_i  = raddr_b;
    assign bus_b.err_i    = 1'b0;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_b <= 1'b0; raddr_b <= '0;
        end else begin
            pend_b <= bus_b.req_o;
            if (bus_b.req_o) raddr_b <= bus_b.addr_o;
        end
    end

    logic [36:0] wr_q [$];
    logic [31:0] addr_q_b [$];
    int          wr_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor_a();
        logic        st_pend = 1'b0;
        logic [31:0] st_addr = '0;
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rf_we) begin
                wr_cnt++;
                chk("wr_expected", (wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    chk("rf_write", {rf_waddr, rf_wdata}, e);
                end
            end
            if (st_pend) chk("req_stable", {bus.req_o, bus.addr_o}, {1'b1, st_addr});
            st_pend = bus.req_o && !bus.gnt_i;
            st_addr = bus.addr_o;
        end
    endtask

    task automatic monitor_b();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (bus_b.req_o) begin
                chk("b_addr_expected", (addr_q_b.size() != 0), 1);
                if (addr_q_b.size() != 0) begin
                    e = addr_q_b.pop_front();
                    chk("b_addr", bus_b.addr_o, e);
                end
            end
            if (done_b) chk("b_pc", {pc_valid_b, pc_b}, {1'b1, 32'h180});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {halt, rf_we, pc_valid, done, err_o, bus.req_o}, 0);
        chk({tag, "_data"}, {rf_waddr, rf_wdata, pc, bus.addr_o}, 0);
    endtask

    task automatic run(input string tag, input int exp_done, input int n_wr, input bit exp_err,
                       input int spur_cyc, input int probe_cyc, input logic [31:0] probe_addr,
                       input bit with_b);
        int halt_cnt = 0;
        int done_n = -1;
        for (int i = 1; i <= n_wr; i++) wr_q.push_back({5'(i), mem[i]});
        if (with_b) for (int k = 1; k <= 32; k++) addr_q_b.push_back(32'h100 + 32'(k * 4));
        wr_cnt = 0;
        @(negedge clk); recover = 1'b1; recover_b = with_b;
        @(negedge clk); recover = 1'b0; recover_b = 1'b0;
        chk({tag, "_start"}, {halt, err_o}, 2'b10);
        for (int n = 1; n < 300; n++) begin
            recover = (n == spur_cyc);
            if (n == probe_cyc) chk({tag, "_probe"}, {bus.req_o, bus.addr_o}, {1'b1, probe_addr});
            if (halt) halt_cnt++;
            if (done) begin done_n = n; break; end
            @(negedge clk);
        end
        recover = 1'b0;
        chk({tag, "_done_cyc"}, done_n, exp_done);
        chk({tag, "_fin"}, {pc_valid, err_o}, {!exp_err, exp_err});
        if (!exp_err) chk({tag, "_pc"}, pc, mem[32]);
        chk({tag, "_halt_cnt"}, halt_cnt, exp_done);
        @(negedge clk);
        chk({tag, "_idle"}, {halt, done, pc_valid}, 0);
        chk({tag, "_wr_cnt"}, wr_cnt, n_wr);
        chk({tag, "_wr_q"}, wr_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = (i >= 1 && i <= 31) ? 32'hA000_0000 + 32'(i) : 32'h0;
            gnt_hold[i] = 0;
            rv_lat[i] = 1;
        end
        mem[32] = 32'h0000_0400;
        fork
            monitor_a();
            monitor_b();
        join_none

        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset_b", {halt_b, bus_b.req_o, bus_b.addr_o, pc_b, err_b}, 0);
        rst_ni = 1'b1;

        run("clean", 65, 31, 1'b0, 0, 0, 32'h0, 1'b1);
        chk("b_addr_q", addr_q_b.size(), 0);

        gnt_hold[5] = 3; rv_lat[20] = 2;
        run("stall", 69, 31, 1'b0, 0, 10, 32'h14, 1'b0);
        gnt_hold[5] = 0; rv_lat[20] = 1;

        err_idx = 6'd10;
        run("err", 21, 9, 1'b1, 0, 0, 32'h0, 1'b0);
        err_idx = 6'd0;
        repeat (3) @(negedge clk);
        chk("err_sticky", {err_o, pc_valid, halt}, 3'b100);

        wr_cnt = 0;
        spur_rv = 1'b1;
        @(negedge clk); spur_rv = 1'b0;
        @(negedge clk);
        chk("spur_rv_idle", {wr_cnt, halt}, 0);
        run("spur", 65, 31, 1'b0, 30, 0, 32'h0, 1'b0);

        for (int i = 1; i <= 11; i++) wr_q.push_back({5'(i), mem[i]});
        wr_cnt = 0;
        @(negedge clk); recover = 1'b1;
        @(negedge clk); recover = 1'b0;
        repeat (23) @(negedge clk);
        chk("rst_pre", {halt, bus.req_o, 32'(wr_cnt)}, {2'b10, 32'd11});
        rst_ni = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk); rst_ni = 1'b1;
        chk("rst_wr_q", wr_q.size(), 0);
        @(negedge clk);
        chk("rst_idle", halt, 0);
        run("restart", 65, 31, 1'b0, 0, 0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
